// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: fetch FSM states, boot address, PC step.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam int unsigned PC_INC           = 4;

  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return (pc_lo != 2'b00);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; push and pop may coincide on a full FIFO.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o   = (count_q == (AW+1)'(0));
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Pointer and occupancy tracking; flush wins over any push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= AW'(0);
      wr_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
    end else if (flush_i) begin
      rd_ptr_q <= AW'(0);
      wr_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while unoccupied.
  always_ff @(posedge clk_i) begin
    if (do_push_s && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-based request issue, in-order response matching,
// redirect flush with stale-response dropping, and a sticky misaligned-target halt.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic            halt_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = 32 + XLEN;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            halt_err_q, halt_err_d;

  logic            redir_s, redir_bad_s, credit_s, req_valid_s, accept_s;
  logic            rsp_s, keep_rsp_s, q_push_s, q_pop_s, q_empty_s;
  logic [XLEN-1:0] pcf_head_s;
  logic [QW-1:0]   q_head_s;
  logic [CW-1:0]   q_count_s, pcf_count_s;
  logic            pcf_empty_s, pcf_full_s, q_full_s;

  // In HALT redirects are ignored; the only way out is reset.
  assign redir_s     = redirect_valid && (state_q != HALT);
  assign redir_bad_s = redir_s && is_misaligned(redirect_pc[1:0]);
  assign credit_s    = ({1'b0, outstanding_q} + {1'b0, q_count_s}) < (CW+1)'(DEPTH);
  assign accept_s    = req_valid_s && imem_req_ready;
  assign rsp_s       = imem_rsp_valid && (outstanding_q != CW'(0));
  assign keep_rsp_s  = rsp_s && (drop_cnt_q == CW'(0));
  assign q_push_s    = keep_rsp_s && (state_q == RUN) && !redir_s;
  assign q_pop_s     = out_valid && out_ready && !redir_s;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = redir_bad_s ? HALT : RUN;
      RUN:     state_d = redir_bad_s ? HALT : RUN;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // FSM outputs: request issue is blocked during a redirect cycle.
  always_comb begin
    req_valid_s = 1'b0;
    if (state_q == RUN) req_valid_s = credit_s && !redir_s;
    else                req_valid_s = 1'b0;
  end

  // Datapath next-state: fetch PC, in-flight count, drop count, sticky error.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    halt_err_d    = halt_err_q | redir_bad_s;
    case ({accept_s, rsp_s})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if (redir_s && !redir_bad_s)      fetch_pc_d = redirect_pc;
    else if (accept_s)                fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
    else                              fetch_pc_d = fetch_pc_q;
    // Every request still in flight after this edge belongs to the old path.
    if (redir_s)                              drop_cnt_d = outstanding_d;
    else if (rsp_s && drop_cnt_q != CW'(0))   drop_cnt_d = drop_cnt_q - CW'(1);
    else                                      drop_cnt_d = drop_cnt_q;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= CW'(0);
      drop_cnt_q    <= CW'(0);
      halt_err_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      halt_err_q    <= halt_err_d;
    end
  end

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .flush_i (redir_s),
    .push_i  (accept_s),
    .data_i  (fetch_pc_q),
    .pop_i   (keep_rsp_s),
    .data_o  (pcf_head_s),
    .empty_o (pcf_empty_s),
    .full_o  (pcf_full_s),
    .count_o (pcf_count_s)
  );

  sync_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_instr_q (
    .clk_i   (clk),
    .rst_ni  (reset),
    .flush_i (redir_s),
    .push_i  (q_push_s),
    .data_i  ({imem_rsp_data, pcf_head_s}),
    .pop_i   (q_pop_s),
    .data_o  (q_head_s),
    .empty_o (q_empty_s),
    .full_o  (q_full_s),
    .count_o (q_count_s)
  );

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_q;
  assign out_valid      = !q_empty_s;
  assign out_instr      = out_valid ? q_head_s[QW-1:XLEN] : 32'h0000_0000;
  assign out_pc         = out_valid ? q_head_s[XLEN-1:0] : XLEN'(0);
  assign out_pc_plus4   = out_pc + XLEN'(PC_INC);
  assign halt_err       = halt_err_q;

endmodule
